// File: rtl/cpu16_boot_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cpu16_boot_loader_if : host byte link plus program-memory write port
// Revision 1.0
// ---------------------------------------------------------------------------
interface cpu16_boot_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] pm_address;
  logic [15:0] pm_data_out;
  logic        pm_write;

  // master = host/memory side, slave = loader
  modport master (
    output in_valid, in_data,
    input  in_ready, pm_address, pm_data_out, pm_write
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, pm_address, pm_data_out, pm_write
  );
endinterface
`default_nettype wire

// File: rtl/cpu16_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cpu16_boot_loader : framed byte-stream loader into program memory
// Revision 1.0
// ---------------------------------------------------------------------------
module cpu16_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          PM_DEPTH  = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  wire logic          clock,
  input  wire logic          reset,
  cpu16_boot_loader_if.slave bus,
  input  wire logic          load_req,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CNT_HI  = 3'd1,
    S_CNT_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam logic [16:0] DEPTH_LIMIT = 17'(PM_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] idx_q, idx_d;
  logic        pm_write_q, pm_write_d;
  logic [15:0] pm_address_q, pm_address_d;
  logic [15:0] pm_data_out_q, pm_data_out_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        in_ready;
  logic        accept;
  logic [7:0]  sum_next;
  logic [15:0] idx_next;
  logic [15:0] n_words;

  assign in_ready = (state_q != S_RUN);
  assign accept   = bus.in_valid & in_ready;
  assign sum_next = sum_q + bus.in_data;
  assign idx_next = idx_q + 16'd1;
  assign n_words  = {cnt_q[15:8], bus.in_data};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    pm_write_d    = 1'b0;
    pm_address_d  = pm_address_q;
    pm_data_out_d = pm_data_out_q;
    cpu_reset_d   = cpu_reset_q;
    done_d        = done_q;
    error_d       = error_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (accept && bus.in_data == SYNC_BYTE) begin
          state_d = S_CNT_HI;
          sum_d   = 8'h00;
          idx_d   = 16'h0000;
          error_d = 1'b0;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_d   = {bus.in_data, 8'h00};
          sum_d   = sum_next;
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d = n_words;
          sum_d = sum_next;
          if ({1'b0, n_words} > DEPTH_LIMIT) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (n_words == 16'h0000) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = bus.in_data;
          sum_d   = sum_next;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        // Write is registered so the strobe appears the cycle after the low byte
        if (accept) begin
          sum_d         = sum_next;
          pm_write_d    = 1'b1;
          pm_data_out_d = {hi_q, bus.in_data};
          pm_address_d  = BASE_ADDR + idx_q;
          idx_d         = idx_next;
          state_d       = (idx_next == cnt_q) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (sum_next == 8'h00) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (load_req) begin
          state_d     = S_IDLE;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'h0000;
      hi_q          <= 8'h00;
      sum_q         <= 8'h00;
      idx_q         <= 16'h0000;
      pm_write_q    <= 1'b0;
      pm_address_q  <= BASE_ADDR;
      pm_data_out_q <= 16'h0000;
      cpu_reset_q   <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      pm_write_q    <= pm_write_d;
      pm_address_q  <= pm_address_d;
      pm_data_out_q <= pm_data_out_d;
      cpu_reset_q   <= cpu_reset_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.pm_write    = pm_write_q;
  assign bus.pm_address  = pm_address_q;
  assign bus.pm_data_out = pm_data_out_q;
  assign cpu_reset       = cpu_reset_q;
  assign done            = done_q;
  assign error           = error_q;
  assign busy            = (state_q == S_CNT_HI)  || (state_q == S_CNT_LO) ||
                           (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                           (state_q == S_CHECK);

endmodule
`default_nettype wire
